// File: rtl/multicycle_maindec.sv
// Control FSM for the RV32I multicycle core: walks each instruction through
// fetch/decode/execute/memory/writeback and drives datapath enables and selects.
`timescale 1ns/1ps
module multicycle_maindec #(
    parameter int unsigned MEM_HANDSHAKE = 0,
    parameter int unsigned EN_UTYPE      = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       MemReq,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic       InstrDone,
    output logic       Illegal
);

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTER, S_EXECUTEI, S_LUI, S_AUIPC, S_JAL, S_ALUWB, S_BEQ, S_ILLEGAL
    } state_t;

    state_t state, state_next;
    logic   pc_update;
    logic   branch;
    logic   mem_done;
    logic   utype_en;

    // Without the handshake every memory access completes in its first cycle.
    assign mem_done = (MEM_HANDSHAKE == 0) ? 1'b1 : MemReady;
    assign utype_en = (EN_UTYPE != 0);
    assign PCWrite  = pc_update | (branch & Zero);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        pc_update  = 1'b0;
        branch     = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        MemReq     = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        InstrDone  = 1'b0;
        Illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                MemReq    = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (mem_done) begin
                    IRWrite    = 1'b1;
                    pc_update  = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target is precomputed here into ALUOut.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_EXECUTER;
                    OP_I:         state_next = S_EXECUTEI;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_JAL:       state_next = S_JAL;
                    OP_LUI:       state_next = utype_en ? S_LUI : S_ILLEGAL;
                    OP_AUIPC:     state_next = utype_en ? S_AUIPC : S_ILLEGAL;
                    default:      state_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                state_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                MemReq = 1'b1;
                if (mem_done) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                RegWrite   = 1'b1;
                InstrDone  = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                MemReq = 1'b1;
                if (mem_done) begin
                    MemWrite   = 1'b1;
                    InstrDone  = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_EXECUTER: begin
                ALUSrcA    = 2'b10;
                ALUOp      = 2'b10;
                state_next = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUOp      = 2'b10;
                state_next = S_ALUWB;
            end
            S_LUI: begin
                ALUSrcA    = 2'b11;
                ALUSrcB    = 2'b01;
                state_next = S_ALUWB;
            end
            S_AUIPC: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b01;
                state_next = S_ALUWB;
            end
            S_JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                pc_update  = 1'b1;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                InstrDone  = 1'b1;
                state_next = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA    = 2'b10;
                ALUOp      = 2'b01;
                branch     = 1'b1;
                InstrDone  = 1'b1;
                state_next = S_FETCH;
            end
            S_ILLEGAL: begin
                Illegal    = 1'b1;
                state_next = S_ILLEGAL;
            end
            default: state_next = S_ILLEGAL;
        endcase
    end

    // Immediate format depends only on the opcode, never on the state.
    always_comb begin
        ImmSrc = 3'b000;
        case (op)
            OP_SW:            ImmSrc = 3'b001;
            OP_BEQ:           ImmSrc = 3'b010;
            OP_JAL:           ImmSrc = 3'b011;
            OP_LUI, OP_AUIPC: ImmSrc = utype_en ? 3'b100 : 3'b000;
            default:          ImmSrc = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_multicycle_maindec.sv
// Scoreboard bench for multicycle_maindec: instance a has no handshake with U-type,
// instance b has the memory handshake with U-type disabled.
`timescale 1ns/1ps
module tb_multicycle_maindec;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] BEQ = 7'b1100011, JAL = 7'b1101111;
    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111;
    localparam logic [2:0] IM_I = 3'b000, IM_S = 3'b001, IM_B = 3'b010, IM_J = 3'b011, IM_U = 3'b100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b, zero_a, zero_b, rdy_a, rdy_b;
    logic [6:0] op_a, op_b;
    wire  [18:0] out_a, out_b;

    multicycle_maindec #(.MEM_HANDSHAKE(0), .EN_UTYPE(1)) dut_a (
        .clk(clk), .reset(rst_a), .op(op_a), .Zero(zero_a), .MemReady(rdy_a),
        .PCWrite(out_a[18]), .AdrSrc(out_a[17]), .MemWrite(out_a[16]), .MemReq(out_a[15]),
        .IRWrite(out_a[14]), .RegWrite(out_a[13]), .ResultSrc(out_a[12:11]),
        .ALUSrcA(out_a[10:9]), .ALUSrcB(out_a[8:7]), .ALUOp(out_a[6:5]),
        .ImmSrc(out_a[4:2]), .InstrDone(out_a[1]), .Illegal(out_a[0]));

    multicycle_maindec #(.MEM_HANDSHAKE(1), .EN_UTYPE(0)) dut_b (
        .clk(clk), .reset(rst_b), .op(op_b), .Zero(zero_b), .MemReady(rdy_b),
        .PCWrite(out_b[18]), .AdrSrc(out_b[17]), .MemWrite(out_b[16]), .MemReq(out_b[15]),
        .IRWrite(out_b[14]), .RegWrite(out_b[13]), .ResultSrc(out_b[12:11]),
        .ALUSrcA(out_b[10:9]), .ALUSrcB(out_b[8:7]), .ALUOp(out_b[6:5]),
        .ImmSrc(out_b[4:2]), .InstrDone(out_b[1]), .Illegal(out_b[0]));

    typedef struct {
        logic        sel;
        logic [18:0] v;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    event mid_ev;

    function automatic logic [18:0] ov(input logic pcw, adr, mw, mr, irw, rw,
                                       input logic [1:0] rs, sa, sb, aop,
                                       input logic [2:0] imm, input logic done, ill);
        return {pcw, adr, mw, mr, irw, rw, rs, sa, sb, aop, imm, done, ill};
    endfunction

    function automatic logic [18:0] v_fetch(input logic [2:0] i);  return ov(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,i,0,0); endfunction
    function automatic logic [18:0] v_fwait(input logic [2:0] i);  return ov(0,0,0,1,0,0,2'b10,2'b00,2'b10,2'b00,i,0,0); endfunction
    function automatic logic [18:0] v_dec(input logic [2:0] i);    return ov(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,i,0,0); endfunction
    function automatic logic [18:0] v_madr(input logic [2:0] i);   return ov(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,i,0,0); endfunction
    function automatic logic [18:0] v_mread(input logic [2:0] i);  return ov(0,1,0,1,0,0,2'b00,2'b00,2'b00,2'b00,i,0,0); endfunction
    function automatic logic [18:0] v_mwb(input logic [2:0] i);    return ov(0,0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,i,1,0); endfunction
    function automatic logic [18:0] v_mwwait(input logic [2:0] i); return ov(0,1,0,1,0,0,2'b00,2'b00,2'b00,2'b00,i,0,0); endfunction
    function automatic logic [18:0] v_mwr(input logic [2:0] i);    return ov(0,1,1,1,0,0,2'b00,2'b00,2'b00,2'b00,i,1,0); endfunction
    function automatic logic [18:0] v_exr(input logic [2:0] i);    return ov(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,i,0,0); endfunction
    function automatic logic [18:0] v_auipc(input logic [2:0] i);  return ov(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,i,0,0); endfunction
    function automatic logic [18:0] v_jal(input logic [2:0] i);    return ov(1,0,0,0,0,0,2'b00,2'b01,2'b10,2'b00,i,0,0); endfunction
    function automatic logic [18:0] v_aluwb(input logic [2:0] i);  return ov(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,i,1,0); endfunction
    function automatic logic [18:0] v_beq(input logic z);          return ov(z,0,0,0,0,0,2'b00,2'b10,2'b00,2'b01,IM_B,1,0); endfunction
    function automatic logic [18:0] v_ill(input logic [2:0] i);    return ov(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,i,0,1); endfunction

    // Expect v for the current cycle, then advance to just after the next edge.
    task automatic cyc(input logic sel, input logic [18:0] v, input string nm);
        q.push_back('{sel, v, nm});
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t        e;
        logic [18:0] act;
        forever begin
            @(negedge clk or mid_ev);
            #1;
            while (q.size() > 0) begin
                e   = q.pop_front();
                act = e.sel ? out_b : out_a;
                n_cmp++;
                if (act !== e.v) begin
                    n_fail++;
                    $display("FAIL %s: got %b expected %b", e.nm, act, e.v);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        op_a = LW; op_b = SW;
        zero_a = 1'b0; zero_b = 1'b0;
        rdy_a = 1'b0; rdy_b = 1'b0;
        @(posedge clk);
        #1;
        cyc(0, v_fetch(IM_I), "a_reset");
        cyc(1, v_fwait(IM_S), "b_reset");

        rst_a = 1'b0;
        cyc(0, v_fetch(IM_I), "lw_fetch");
        cyc(0, v_dec(IM_I),   "lw_decode");
        cyc(0, v_madr(IM_I),  "lw_memadr");
        cyc(0, v_mread(IM_I), "lw_memread");
        cyc(0, v_mwb(IM_I),   "lw_memwb");

        op_a = SW;
        cyc(0, v_fetch(IM_S), "sw_fetch");
        cyc(0, v_dec(IM_S),   "sw_decode");
        cyc(0, v_madr(IM_S),  "sw_memadr");
        cyc(0, v_mwr(IM_S),   "sw_memwrite");

        op_a = BEQ; zero_a = 1'b1;
        cyc(0, v_fetch(IM_B), "beq1_fetch");
        cyc(0, v_dec(IM_B),   "beq1_decode");
        cyc(0, v_beq(1'b1),   "beq_taken");
        zero_a = 1'b0;
        cyc(0, v_fetch(IM_B), "beq2_fetch");
        cyc(0, v_dec(IM_B),   "beq2_decode");
        cyc(0, v_beq(1'b0),   "beq_not_taken");

        op_a = AUIPC; rdy_a = 1'b1;
        cyc(0, v_fetch(IM_U), "auipc_fetch");
        cyc(0, v_dec(IM_U),   "auipc_decode");
        cyc(0, v_auipc(IM_U), "auipc_exec");
        cyc(0, v_aluwb(IM_U), "auipc_aluwb");

        op_a = JAL;
        cyc(0, v_fetch(IM_J), "jal_fetch");
        cyc(0, v_dec(IM_J),   "jal_decode");
        cyc(0, v_jal(IM_J),   "jal_exec");
        cyc(0, v_aluwb(IM_J), "jal_aluwb");

        op_a = LW;
        cyc(0, v_fetch(IM_I), "mr_fetch");
        cyc(0, v_dec(IM_I),   "mr_decode");
        cyc(0, v_madr(IM_I),  "mr_memadr");
        q.push_back('{1'b0, v_mread(IM_I), "mr_memread"});
        #6;
        rst_a = 1'b1;
        q.push_back('{1'b0, v_fetch(IM_I), "mr_async_reset"});
        ->mid_ev;
        @(posedge clk);
        #1;
        cyc(0, v_fetch(IM_I), "mr_reset_hold");
        rst_a = 1'b0;

        op_a = RT;
        cyc(0, v_fetch(IM_I), "r_fetch");
        cyc(0, v_dec(IM_I),   "r_decode");
        cyc(0, v_exr(IM_I),   "r_exec");
        cyc(0, v_aluwb(IM_I), "r_aluwb");

        rst_b = 1'b0; rdy_b = 1'b0;
        cyc(1, v_fwait(IM_S), "hs_fetch_wait");
        rdy_b = 1'b1;
        cyc(1, v_fetch(IM_S), "hs_fetch");
        cyc(1, v_dec(IM_S),   "hs_decode");
        cyc(1, v_madr(IM_S),  "hs_memadr");
        rdy_b = 1'b0;
        cyc(1, v_mwwait(IM_S), "hs_memwrite_wait1");
        cyc(1, v_mwwait(IM_S), "hs_memwrite_wait2");
        rdy_b = 1'b1;
        cyc(1, v_mwr(IM_S),    "hs_memwrite_done");
        rdy_b = 1'b0;
        cyc(1, v_fwait(IM_S),  "hs_back_to_fetch");

        op_b = LUI; rdy_b = 1'b1;
        cyc(1, v_fetch(IM_I), "lui_fetch");
        cyc(1, v_dec(IM_I),   "lui_decode");
        for (int i = 0; i < 20; i++) begin
            rdy_b = i[0];
            cyc(1, v_ill(IM_I), "lui_illegal");
        end
        rst_b = 1'b1; rdy_b = 1'b0;
        cyc(1, v_fwait(IM_I), "ill_reset");
        rst_b = 1'b0;
        cyc(1, v_fwait(IM_I), "ill_after_reset");

        @(negedge clk);
        #2;
        n_cmp++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
